// File: rtl/inst_encoder_pkg.sv
// Shared RV32 encoding types, opcode constants and the pure encode/range-check
// function used by the encoder and by decode round-trip checks.
package inst_encoder_pkg;

  typedef enum logic [3:0] {
    ENC_R     = 4'd0,
    ENC_I     = 4'd1,
    ENC_SHI   = 4'd2,
    ENC_LD    = 4'd3,
    ENC_ST    = 4'd4,
    ENC_B     = 4'd5,
    ENC_LUI   = 4'd6,
    ENC_AUIPC = 4'd7,
    ENC_J     = 4'd8,
    ENC_JALR  = 4'd9
  } enc_fmt_e;

  localparam logic [6:0] RISCV_OP     = 7'h33;
  localparam logic [6:0] RISCV_OPIMM  = 7'h13;
  localparam logic [6:0] RISCV_LOAD   = 7'h03;
  localparam logic [6:0] RISCV_STORE  = 7'h23;
  localparam logic [6:0] RISCV_BRANCH = 7'h63;
  localparam logic [6:0] RISCV_LUI    = 7'h37;
  localparam logic [6:0] RISCV_AUIPC  = 7'h17;
  localparam logic [6:0] RISCV_JAL    = 7'h6F;
  localparam logic [6:0] RISCV_JALR   = 7'h67;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  typedef struct packed {
    logic [3:0]  fmt;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } enc_req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] word;
  } enc_res_t;

  function automatic enc_res_t encode_inst(input enc_req_t r);
    enc_res_t res;
    logic [31:0] w;
    logic e, imm12_ok, immb_ok, immj_ok, shamt_ok, shi_f3_ok, shi_f7_ok;
    // Signed range checks reduce to "upper bits are a pure sign extension".
    imm12_ok  = (r.imm[31:11] == 21'h0) || (r.imm[31:11] == 21'h1F_FFFF);
    immb_ok   = ((r.imm[31:12] == 20'h0) || (r.imm[31:12] == 20'hF_FFFF)) && !r.imm[0];
    immj_ok   = ((r.imm[31:20] == 12'h0) || (r.imm[31:20] == 12'hFFF)) && !r.imm[0];
    shamt_ok  = (r.imm[31:5] == 27'h0);
    shi_f3_ok = (r.funct3 == 3'b001) || (r.funct3 == 3'b101);
    shi_f7_ok = (r.funct7 == 7'b0000000) ||
                ((r.funct7 == 7'b0100000) && (r.funct3 == 3'b101));
    w = 32'h0;
    e = 1'b0;
    case (r.fmt)
      ENC_R: w = {r.funct7, r.rs2, r.rs1, r.funct3, r.rd, RISCV_OP};
      ENC_I: begin
        w = {r.imm[11:0], r.rs1, r.funct3, r.rd, RISCV_OPIMM};
        e = !imm12_ok;
      end
      ENC_SHI: begin
        w = {r.funct7, r.imm[4:0], r.rs1, r.funct3, r.rd, RISCV_OPIMM};
        e = !(shamt_ok && shi_f3_ok && shi_f7_ok);
      end
      ENC_LD: begin
        w = {r.imm[11:0], r.rs1, r.funct3, r.rd, RISCV_LOAD};
        e = !imm12_ok || (r.funct3 == 3'b011) || (r.funct3 == 3'b110) ||
            (r.funct3 == 3'b111);
      end
      ENC_ST: begin
        w = {r.imm[11:5], r.rs2, r.rs1, r.funct3, r.imm[4:0], RISCV_STORE};
        e = !imm12_ok || (r.funct3 > 3'b010);
      end
      ENC_B: begin
        w = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.funct3, r.imm[4:1],
             r.imm[11], RISCV_BRANCH};
        e = !immb_ok || (r.funct3 == 3'b010) || (r.funct3 == 3'b011);
      end
      ENC_LUI: begin
        w = {r.imm[31:12], r.rd, RISCV_LUI};
        e = (r.imm[11:0] != 12'h0);
      end
      ENC_AUIPC: begin
        w = {r.imm[31:12], r.rd, RISCV_AUIPC};
        e = (r.imm[11:0] != 12'h0);
      end
      ENC_J: begin
        w = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, RISCV_JAL};
        e = !immj_ok;
      end
      ENC_JALR: begin
        w = {r.imm[11:0], r.rs1, 3'b000, r.rd, RISCV_JALR};
        e = !imm12_ok;
      end
      default: e = 1'b1;
    endcase
    res.err  = e;
    res.word = e ? NOP : w;
    return res;
  endfunction

endpackage

// File: rtl/inst_encoder_fifo.sv
// Generic DEPTH-entry FIFO; refuses pushes when full even if a pop coincides.
module enc_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == (AW+1)'(0));
  assign rdata = mem_r[rd_ptr_r];

  // Qualify requests against the occupancy at the start of the cycle.
  always_comb begin
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
  end

  // Storage; cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32IM instruction encoder: descriptor in, packed word out through
// a small FIFO, with saturating accept/error counters.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic [3:0]       reqFmt,
  input  logic [2:0]       reqFunct3,
  input  logic [6:0]       reqFunct7,
  input  logic [4:0]       reqRd,
  input  logic [4:0]       reqRs1,
  input  logic [4:0]       reqRs2,
  input  logic [31:0]      reqImm,
  output logic             instValid,
  input  logic             instReady,
  output logic [31:0]      inst,
  output logic             instErr,
  output logic [CNT_W-1:0] acceptCnt,
  output logic [CNT_W-1:0] errCnt
);
  enc_req_t         req_s;
  enc_res_t         enc_s;
  logic             accept_s;
  logic             full_s;
  logic             empty_s;
  logic [32:0]      head_s;
  logic [CNT_W-1:0] acc_cnt_r;
  logic [CNT_W-1:0] err_cnt_r;

  // Pack the descriptor and encode it combinationally.
  always_comb begin
    req_s.fmt    = reqFmt;
    req_s.funct3 = reqFunct3;
    req_s.funct7 = reqFunct7;
    req_s.rd     = reqRd;
    req_s.rs1    = reqRs1;
    req_s.rs2    = reqRs2;
    req_s.imm    = reqImm;
    enc_s        = encode_inst(req_s);
  end

  assign reqReady  = !full_s;
  assign accept_s  = reqValid && !full_s;
  assign instValid = !empty_s;
  assign instErr   = head_s[32];
  assign inst      = head_s[31:0];
  assign acceptCnt = acc_cnt_r;
  assign errCnt    = err_cnt_r;

  enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rstN),
    .push  (accept_s),
    .wdata ({enc_s.err, enc_s.word}),
    .pop   (instReady),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      acc_cnt_r <= '0;
      err_cnt_r <= '0;
    end else begin
      if (accept_s && (acc_cnt_r != '1)) acc_cnt_r <= acc_cnt_r + CNT_W'(1);
      if (accept_s && enc_s.err && (err_cnt_r != '1)) err_cnt_r <= err_cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Streaming RV32IM instruction encoder, the inverse of the decode stage. It accepts a compact per-field instruction descriptor through a valid/ready handshake, range-checks the immediate, packs the fields into a 32-bit RISC-V word and buffers the result in a small FIFO. The FIFO drains through a second valid/ready port. It feeds the self-test instruction injector and trace replay path that sit in front of the decode unit.

Parameters:
DEPTH, 2, output FIFO entries (power of two, at least 2)
CNT_W, 16, width of the accepted and error counters (saturating)

Ports:
clk  in  1  clock, rising edge
rstN  in  1  asynchronous active-low reset
reqValid  in  1  descriptor valid
reqReady  out  1  encoder can accept a descriptor this cycle
reqFmt  in  4  EncFmt: ENC_R, ENC_I, ENC_SHI, ENC_LD, ENC_ST, ENC_B, ENC_LUI, ENC_AUIPC, ENC_J, ENC_JALR
reqFunct3  in  3  funct3 field
reqFunct7  in  7  funct7 field (used by ENC_R and ENC_SHI only)
reqRd  in  5  destination register
reqRs1  in  5  source register 1
reqRs2  in  5  source register 2
reqImm  in  32  immediate, byte offset / full value
instValid  out  1  FIFO head valid
instReady  in  1  consumer takes the head
inst  out  32  encoded instruction word at the head
instErr  out  1  head entry was replaced by NOP because of a range error
acceptCnt  out  CNT_W  descriptors accepted since reset
errCnt  out  CNT_W  descriptors flagged as errors since reset

Behaviour:
- Reset (asynchronous, rstN low): FIFO empty, pointers 0, instValid=0, inst=0, instErr=0, acceptCnt=0, errCnt=0, reqReady=1 after release.
- Accept when reqValid && reqReady. reqReady = (count != DEPTH). There is no full-bypass: a push when full is refused even if a pop happens the same cycle.
- Encoding is combinational on the accepted descriptor and written into the FIFO tail on the accept edge.
- Latency: the word appears at the head (instValid=1) the cycle after acceptance if the FIFO was empty. There is no same-cycle bypass.
- Pop when instValid && instReady. inst and instErr are driven from the head entry and are held stable while instValid && !instReady.
- Simultaneous push and pop at 0 < count < DEPTH: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Opcodes and layouts follow standard RV32:
  - R: 0x33
  - I and SHI: 0x13
  - LD: 0x03
  - ST: 0x23
  - B: 0x63
  - LUI: 0x37
  - AUIPC: 0x17
  - J: 0x6F
  - JALR: 0x67, funct3 forced to 000
  - Unused fields (for example rs2 in I) come from the immediate or are 0, never from stray inputs.
- Range rules (a violation sets err):
  - I, LD, ST, JALR: reqImm must be in [-2048, 2047].
  - SHI: reqImm must be in [0, 31]; funct3 must be 001 or 101; funct7 must be 0000000, or 0100000 only with funct3=101.
  - B: reqImm in [-4096, 4094] and even; funct3 not 010 or 011.
  - J: reqImm in [-2^20, 2^20-2] and even.
  - LUI, AUIPC: reqImm[11:0] must be 0.
  - LD: funct3 in {000, 001, 010, 100, 101}. ST: funct3 in {000, 001, 010}.
  - Unknown reqFmt is an error.
- On error the stored word is 0x00000013 (NOP) with instErr=1, and errCnt increments.
- acceptCnt increments on every accept. Both counters saturate at all-ones.
- Reset asserted mid-operation discards FIFO contents immediately. No partial output is driven after reset.

Decomposition:
- EncFmt enum, opcode constants (RISCV_OP, RISCV_OPIMM, RISCV_LOAD, RISCV_STORE, RISCV_BRANCH, RISCV_LUI, RISCV_AUIPC, RISCV_JAL, RISCV_JALR), NOP constant and the EncReq struct go in OpTypes, shared with decode.
- The pure encode/range-check function EncodeInst goes in the package alongside the decoder functions, so decode-then-encode round-trips can be checked in simulation.
- One sub-module: enc_fifo, a generic DEPTH-entry FIFO of {err, word} with count, full and empty.

Test Plan:
- ENC_I funct3=000 rd=1 rs1=0 imm=5 -> inst=0x00500093, instErr=0, one cycle after accept.
- ENC_B funct3=000 rs1=1 rs2=2 imm=-4 -> 0xFE208EE3; ENC_J rd=1 imm=8 -> 0x008000EF.
- ENC_ST funct3=010 rs1=1 rs2=2 imm=8 -> 0x0020A423; ENC_LUI rd=2 imm=0x12345000 -> 0x12345137.
- ENC_I imm=2048, then ENC_B imm=3 -> two entries 0x00000013 with instErr=1; errCnt=2, acceptCnt=2.
- DEPTH=2, instReady=0, three back-to-back requests -> reqReady=0 after the 2nd accept, 3rd held. Raise instReady -> words drain in order, 3rd accepted the cycle after the first pop, wrap verified.
- Fill 1 entry, drop rstN for one cycle mid-stream -> instValid=0 and both counters 0 asynchronously; a new request then emits correctly.
